axis_slave: RTL and testbench

// - AXI-Stream slave front end: accepts beats from an upstream AXIS master and buffers them in an internal FIFO.
// - Presents buffered beats to a backend through a valid/ready pop interface, with per-packet done and beat-count reporting.
// - Receive-side counterpart of the axilite_axis stream master; sits between the AXIS fabric and user backend logic.

---
 rtl/axis_slave.sv | 152 +++++++++++++++
 tb/tb_axis_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_slave.sv
// axis_slave: AXI-Stream receive front end with a FWFT FIFO and per-packet reporting.
// Ports:
//   axi_aclk, axi_reset      - clock, sync active-high reset
//   axis_t*                  - upstream AXIS slave port (tready = not full)
//   bk_valid/bk_ready, bk_*  - head-of-FIFO pop interface to the backend
//   bk_done, bk_beats        - registered end-of-packet pulse and beat count
//   bk_nodrain               - backend has stalled with data pending too long
module axis_slave #(
    parameter int FIFO_DEPTH     = 8,
    parameter int BK_RDY_TIMEOUT = 5,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 axi_aclk,
    input  logic                 axi_reset,
    input  logic                 axis_tvalid,
    input  logic [31:0]          axis_tdata,
    input  logic [3:0]           axis_tstrb,
    input  logic [3:0]           axis_tkeep,
    input  logic [1:0]           axis_tuser,
    input  logic                 axis_tlast,
    output logic                 axis_tready,
    output logic                 bk_valid,
    output logic [31:0]          bk_data,
    output logic [3:0]           bk_tstrb,
    output logic [3:0]           bk_tkeep,
    output logic [1:0]           bk_user,
    output logic                 bk_last,
    input  logic                 bk_ready,
    output logic                 bk_done,
    output logic [CNT_WIDTH-1:0] bk_beats,
    output logic                 bk_nodrain
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 43;
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] TMO  = CNT_WIDTH'(BK_RDY_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          occ;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [EW-1:0]        head;
    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0] beat_cnt_nxt;
    logic [CNT_WIDTH-1:0] beat_inc;
    logic [CNT_WIDTH-1:0] beats_q;
    logic [CNT_WIDTH-1:0] beats_nxt;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic                 done_q;
    logic                 done_nxt;

    assign full  = (occ == DEPTH);
    assign empty = (occ == '0);

    // Reset gates the handshakes so nothing moves while axi_reset is high.
    assign axis_tready = ~full & ~axi_reset;
    assign bk_valid    = ~empty & ~axi_reset;
    assign push        = axis_tvalid & axis_tready;
    assign pop         = bk_valid & bk_ready;

    assign head = bk_valid ? mem[rd_ptr] : '0;
    assign {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last} = head;

    assign bk_done    = done_q & ~axi_reset;
    assign bk_beats   = axi_reset ? '0 : beats_q;
    assign bk_nodrain = ~axi_reset & (stall_cnt >= TMO);

    // Storage has no reset; only occupancy decides what is valid.
    always_ff @(posedge axi_aclk) begin
        if (push)
            mem[wr_ptr] <= {axis_tdata, axis_tstrb, axis_tkeep,
                            axis_tuser, axis_tlast};
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign beat_inc = (beat_cnt == CMAX) ? beat_cnt : beat_cnt + ONE;

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        beats_nxt    = beats_q;
        done_nxt     = 1'b0;
        if (pop) begin
            unique case (state)
                IDLE: begin
                    if (bk_last) begin
                        done_nxt  = 1'b1;
                        beats_nxt = ONE;
                    end else begin
                        state_nxt    = IN_PKT;
                        beat_cnt_nxt = ONE;
                    end
                end
                IN_PKT: begin
                    if (bk_last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        beats_nxt = beat_inc;
                    end else begin
                        beat_cnt_nxt = beat_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            beats_q   <= '0;
            done_q    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            beats_q  <= beats_nxt;
            done_q   <= done_nxt;
            if (bk_valid & ~bk_ready)
                stall_cnt <= (stall_cnt == CMAX) ? stall_cnt
                                                 : stall_cnt + ONE;
            else
                stall_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_axis_slave.sv
// tb_axis_slave: scoreboard bench for axis_slave.
// Accepted beats queue up as expectations; a monitor checks every pop and bk_done.
module tb_axis_slave;
    logic        axi_aclk = 1'b0;
    logic        axi_reset;
    logic        axis_tvalid;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tstrb;
    logic [3:0]  axis_tkeep;
    logic [1:0]  axis_tuser;
    logic        axis_tlast;
    logic        axis_tready;
    logic        bk_valid;
    logic [31:0] bk_data;
    logic [3:0]  bk_tstrb;
    logic [3:0]  bk_tkeep;
    logic [1:0]  bk_user;
    logic        bk_last;
    logic        bk_ready;
    logic        bk_done;
    logic [7:0]  bk_beats;
    logic        bk_nodrain;

    axis_slave #(.FIFO_DEPTH(8), .BK_RDY_TIMEOUT(5), .CNT_WIDTH(8)) dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .axis_tvalid(axis_tvalid), .axis_tdata(axis_tdata),
        .axis_tstrb(axis_tstrb), .axis_tkeep(axis_tkeep),
        .axis_tuser(axis_tuser), .axis_tlast(axis_tlast),
        .axis_tready(axis_tready), .bk_valid(bk_valid),
        .bk_data(bk_data), .bk_tstrb(bk_tstrb), .bk_tkeep(bk_tkeep),
        .bk_user(bk_user), .bk_last(bk_last), .bk_ready(bk_ready),
        .bk_done(bk_done), .bk_beats(bk_beats), .bk_nodrain(bk_nodrain)
    );

    always #5 axi_aclk = ~axi_aclk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [42:0] exp_q[$];
    int          run = 0;
    bit          done_pend = 0;
    int          pend_beats = 0;
    int          done_cnt = 0;
    int          accepted = 0;
    int          tr_waits = 0;
    bit          sender_busy = 0;
    bit          rnd_on = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops compare against the queue; tlast beats schedule a
    // bk_done/bk_beats expectation for the following cycle.
    always @(negedge axi_aclk) begin
        logic [42:0] act;
        logic [42:0] exp;
        bit          pend_now;
        pend_now  = done_pend;
        done_pend = 0;
        if (pend_now || bk_done === 1'b1)
            check("bk_done", bk_done, 64'(pend_now));
        if (pend_now)
            check("bk_beats", bk_beats, 64'(pend_beats));
        if (bk_done === 1'b1) done_cnt++;
        if (bk_valid === 1'b1 && bk_ready === 1'b1) begin
            act = {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last};
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 64'(act), 64'(0));
            end else begin
                exp = exp_q.pop_front();
                check("beat", 64'(act), 64'(exp));
                run = (run >= 255) ? 255 : run + 1;
                if (exp[0]) begin
                    done_pend  = 1;
                    pend_beats = run;
                    run        = 0;
                end
            end
        end
    end

    always @(posedge axi_aclk) begin
        if (rnd_on) begin
            #1;
            bk_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s,
                             input logic [3:0] k, input logic [1:0] u,
                             input logic l);
        int t;
        bit ok;
        axis_tdata  = d;
        axis_tstrb  = s;
        axis_tkeep  = k;
        axis_tuser  = u;
        axis_tlast  = l;
        axis_tvalid = 1'b1;
        t  = 0;
        ok = 0;
        while (!ok && t < 400) begin
            @(negedge axi_aclk);
            if (axis_tready === 1'b1) begin
                exp_q.push_back({d, s, k, u, l});
                accepted++;
                ok = 1;
            end else begin
                tr_waits++;
                t++;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge axi_aclk);
        #1;
        axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base,
                            input bit last);
        for (int i = 0; i < n; i++)
            send_beat(base + 32'(i), 4'hF, 4'(i), 2'(i),
                      last && (i == n - 1));
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || done_pend) && t < 2000) begin
            @(negedge axi_aclk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", 0, 1);
        tick(2);
    endtask

    task automatic wait_sender();
        int t = 0;
        while (sender_busy && t < 2000) begin
            tick(1);
            t++;
        end
        if (t >= 2000) check("sender_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        axi_reset = 1'b1;
        exp_q.delete();
        run       = 0;
        done_pend = 0;
        @(negedge axi_aclk);
        check("rst_bk_valid", bk_valid, 0);
        check("rst_tready", axis_tready, 0);
        @(posedge axi_aclk);
        #1;
        axi_reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        int d0;
        axi_reset   = 1'b1;
        axis_tvalid = 1'b0;
        axis_tdata  = '0;
        axis_tstrb  = '0;
        axis_tkeep  = '0;
        axis_tuser  = '0;
        axis_tlast  = 1'b0;
        bk_ready    = 1'b0;
        tick(2);
        @(negedge axi_aclk);
        check("rst_tready", axis_tready, 0);
        check("rst_bk_done", bk_done, 0);
        @(posedge axi_aclk);
        #1;
        axi_reset = 1'b0;
        @(negedge axi_aclk);
        check("init_tready", axis_tready, 1);
        check("init_bk_valid", bk_valid, 0);
        check("init_bk_data", bk_data, 0);
        check("init_bk_nodrain", bk_nodrain, 0);
        check("init_bk_beats", bk_beats, 0);
        tick(1);

        // single beat, one-cycle accept-to-valid latency
        bk_ready = 1'b0;
        d0 = done_cnt;
        send_beat(32'hA5A5_0001, 4'hF, 4'hF, 2'd1, 1'b1);
        @(negedge axi_aclk);
        check("single_valid", bk_valid, 1);
        check("single_data", bk_data, 32'hA5A5_0001);
        tick(1);
        bk_ready = 1'b1;
        drain();
        check("single_done_cnt", 64'(done_cnt - d0), 1);
        check("single_beats_hold", bk_beats, 1);

        // 4 beats back-to-back
        tr_waits = 0;
        d0 = done_cnt;
        send_pkt(4, 32'h10, 1);
        check("b2b_tready_waits", 64'(tr_waits), 0);
        drain();
        check("b2b_done_cnt", 64'(done_cnt - d0), 1);
        check("b2b_beats", bk_beats, 4);

        // backend stalled, 10 beats offered
        bk_ready = 1'b0;
        accepted = 0;
        d0 = done_cnt;
        sender_busy = 1;
        fork
            begin
                send_pkt(10, 32'h100, 1);
                sender_busy = 0;
            end
        join_none
        @(posedge axi_aclk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge axi_aclk);
            check($sformatf("nodrain_k%0d", k), bk_nodrain,
                  64'(k >= 6));
        end
        tick(4);
        @(negedge axi_aclk);
        check("full_tready", axis_tready, 0);
        check("full_accepted", 64'(accepted), 8);
        tick(1);
        bk_ready = 1'b1;
        @(negedge axi_aclk);
        check("nodrain_pop_cycle", bk_nodrain, 1);
        @(negedge axi_aclk);
        check("nodrain_cleared", bk_nodrain, 0);
        tick(1);
        wait_sender();
        drain();
        check("stall_accepted", 64'(accepted), 10);
        check("stall_done_cnt", 64'(done_cnt - d0), 1);
        check("stall_beats", bk_beats, 10);

        // full FIFO with a single-cycle pop
        bk_ready = 1'b0;
        d0 = done_cnt;
        sender_busy = 1;
        fork
            begin
                send_pkt(12, 32'h200, 1);
                sender_busy = 0;
            end
        join_none
        tick(12);
        @(negedge axi_aclk);
        check("full2_tready", axis_tready, 0);
        tick(1);
        bk_ready = 1'b1;
        @(negedge axi_aclk);
        check("full2_pop_tready", axis_tready, 0);
        tick(1);
        bk_ready = 1'b0;
        @(negedge axi_aclk);
        check("full2_after_pop_tready", axis_tready, 1);
        tick(1);
        @(negedge axi_aclk);
        check("full2_refilled", axis_tready, 0);
        tick(1);
        bk_ready = 1'b1;
        wait_sender();
        drain();
        check("full2_done_cnt", 64'(done_cnt - d0), 1);
        check("full2_beats", bk_beats, 12);

        // reset mid-packet
        bk_ready = 1'b1;
        send_pkt(2, 32'h300, 0);
        tick(2);
        bk_ready = 1'b0;
        send_pkt(3, 32'h310, 0);
        tick(2);
        @(negedge axi_aclk);
        check("mid_pkt_valid", bk_valid, 1);
        tick(1);
        pulse_reset();
        @(negedge axi_aclk);
        check("post_rst_valid", bk_valid, 0);
        check("post_rst_tready", axis_tready, 1);
        tick(1);
        bk_ready = 1'b1;
        d0 = done_cnt;
        send_pkt(2, 32'h320, 1);
        drain();
        check("post_rst_done_cnt", 64'(done_cnt - d0), 1);
        check("post_rst_beats", bk_beats, 2);

        // beat count saturation
        send_pkt(300, 32'h1000, 1);
        drain();
        check("sat_beats", bk_beats, 255);

        // 20 random packets, random tvalid and bk_ready
        d0 = done_cnt;
        rnd_on = 1;
        for (int p = 0; p < 20; p++) begin
            int n;
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) begin
                int g = 0;
                while ($urandom_range(0, 1) == 1 && g < 8) begin
                    tick(1);
                    g++;
                end
                send_beat($urandom, 4'($urandom), 4'($urandom),
                          2'($urandom), i == n - 1);
            end
        end
        rnd_on = 0;
        tick(2);
        bk_ready = 1'b1;
        drain();
        check("rnd_done_cnt", 64'(done_cnt - d0), 20);
        check("rnd_empty", bk_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
